// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mult_state_e;

   localparam int MULT_DEFAULT_WIDTH = 8;

   // Counter must hold WIDTH itself (it steps once more on the final BUSY cycle).
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/fa.sv
// One-bit full-adder cell, the building block of the ripple-carry adder.
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_adder.sv
// N-bit ripple-carry adder built as a combinational chain of fa cells.
module rca_adder #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] w_carry;

   assign w_carry[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_fa
      fa u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (w_carry[i]),
         .sum  (sum[i]),
         .cout (w_carry[i+1])
      );
   end

   assign cout = w_carry[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned radix-2 shift-add multiplier with valid/ready on both sides.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_DEFAULT_WIDTH
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [2*WIDTH-1:0] p_o,
   output logic               busy_o
);

   localparam int PW                = 2 * WIDTH;
   localparam int CNT_W             = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mult_state_e      r_state;
   logic [PW-1:0]    r_acc;
   logic [PW-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [CNT_W-1:0] r_cnt;
   logic [PW-1:0]    r_p;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;

   logic [PW-1:0]    w_addend;
   logic [PW-1:0]    w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_mplier_next;
   logic             w_last;

   // Masking the addend makes w_sum the updated accumulator whether or not this bit adds.
   assign w_addend      = r_mplier[0] ? r_mcand : '0;
   assign w_mplier_next = r_mplier >> 1;

   rca_adder #(
      .N (PW)
   ) u_rca (
      .a    (r_acc),
      .b    (w_addend),
      .cin  (1'b0),
      .sum  (w_sum),
      .cout (w_cout)
   );

`ifdef MULT_EARLY_EXIT_EN
   assign w_last = (r_cnt == LAST_CNT) || (w_mplier_next == '0);
`else
   assign w_last = (r_cnt == LAST_CNT);
`endif

   // NOTE: every register here uses <= so all state advances together on the edge;
   // blocking assignments would let later statements see this cycle's new values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_cnt       <= '0;
         r_p         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid_i && r_in_ready) begin
                  r_acc      <= '0;
                  r_mcand    <= {{WIDTH{1'b0}}, a_i};
                  r_mplier   <= b_i;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               // The partial sum never exceeds 2*WIDTH bits, so a carry-out means a broken adder.
               assert (!w_cout);
               r_acc    <= w_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= w_mplier_next;
               r_cnt    <= r_cnt + CNT_ONE;
               if (w_last) begin
                  r_p         <= w_sum;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = r_out_valid;
   assign p_o         = r_p;
   assign busy_o      = r_busy;

endmodule
